// File: rtl/pipe_pkg.sv
// Shared types and helpers for the pipeline hazard/forwarding controller:
// forwarding select encodings, shadow-slot tag structs and the tag match rule.
package pipe_pkg;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   // Tags are stored at a fixed width; register numbers are zero-extended into it.
   localparam int unsigned TAG_AW = 16;

   typedef logic [TAG_AW-1:0] reg_id_t;

   typedef struct packed {
      logic    valid;
      reg_id_t rs;
      reg_id_t rt;
      reg_id_t dst;
      logic    regwrite;
      logic    memread;
   } ex_tag_t;

   typedef struct packed {
      logic    valid;
      reg_id_t dst;
      logic    regwrite;
      logic    memread;
   } mem_tag_t;

   typedef struct packed {
      logic    valid;
      reg_id_t dst;
      logic    regwrite;
   } wb_tag_t;

   typedef enum logic [0:0] {
      StRun,
      StFreeze
   } frz_state_e;

   // Register $0 is hard-wired to zero and never produces a hazard.
   function automatic logic tag_match(input logic    valid,
                                      input logic    regwrite,
                                      input reg_id_t dst,
                                      input reg_id_t opnd);
      return valid & regwrite & (dst != '0) & (dst == opnd);
   endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Single-operand EX forwarding selector: EX/MEM (non-load) beats MEM/WB beats regfile.
module hazard_fwd_sel
   import pipe_pkg::*;
(
   input  reg_id_t    operand_i,
   input  mem_tag_t   mem_tag_i,
   input  wb_tag_t    wb_tag_i,
   output logic [1:0] sel_o
);

   logic mem_hit;
   logic wb_hit;

   always_comb begin
      mem_hit = tag_match(mem_tag_i.valid, mem_tag_i.regwrite, mem_tag_i.dst, operand_i);
      wb_hit  = tag_match(wb_tag_i.valid, wb_tag_i.regwrite, wb_tag_i.dst, operand_i);
      sel_o   = FWD_REG;
      // Load data is not yet available at the EX/MEM register.
      if (mem_hit && !mem_tag_i.memread) begin
         sel_o = FWD_MEM;
      end else if (wb_hit) begin
         sel_o = FWD_WB;
      end
   end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard and forwarding controller for the 5-stage pipeline: shadow tag pipeline,
// load-use stall, branch flush and multi-cycle load freeze. HAZARD_PERF_EN adds counters.
module pipe_hazard_unit
   import pipe_pkg::*;
#(
   parameter int unsigned REG_AW  = 5,
   parameter int unsigned MEM_LAT = 1,
   parameter int unsigned PERF_W  = 32
) (
   input  logic              clk,
   input  logic              startin,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_uses_rs,
   input  logic              id_uses_rt,
   input  logic [REG_AW-1:0] id_dst,
   input  logic              id_regwrite,
   input  logic              id_memread,
   input  logic              mem_branch_taken,
   output logic              pc_en,
   output logic              if_id_en,
   output logic              id_ex_en,
   output logic              ex_mem_en,
   output logic              mem_wb_en,
   output logic              if_id_flush,
   output logic              id_ex_flush,
   output logic              ex_mem_flush,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
`ifdef HAZARD_PERF_EN
   output logic [PERF_W-1:0] stall_cnt,
   output logic [PERF_W-1:0] flush_cnt,
`endif
   output logic              id_byp_a,
   output logic              id_byp_b
);

   localparam logic       FreezeEn = (MEM_LAT > 1);
   localparam logic [3:0] LatLast  = (MEM_LAT > 1) ? 4'(MEM_LAT - 2) : 4'd0;

   ex_tag_t    ex_q, ex_d;
   mem_tag_t   mem_q, mem_d;
   wb_tag_t    wb_q, wb_d;
   frz_state_e frz_q;
   logic [3:0] lat_cnt_q;

   reg_id_t id_rs_w;
   reg_id_t id_rt_w;
   reg_id_t id_dst_w;
   logic    frozen;
   logic    branch;
   logic    ld_use;
   logic    stall;

   assign id_rs_w  = TAG_AW'(id_rs);
   assign id_rt_w  = TAG_AW'(id_rt);
   assign id_dst_w = TAG_AW'(id_dst);

   // Hazard detection and stage control.
   always_comb begin
      frozen = (frz_q == StFreeze);
      branch = !frozen && mem_branch_taken;
      ld_use = id_valid && ex_q.valid && ex_q.memread &&
               ((id_uses_rs && tag_match(ex_q.valid, ex_q.regwrite, ex_q.dst, id_rs_w)) ||
                (id_uses_rt && tag_match(ex_q.valid, ex_q.regwrite, ex_q.dst, id_rt_w)));
      stall  = !frozen && !branch && ld_use;

      pc_en        = !frozen && !stall;
      if_id_en     = !frozen && !stall;
      id_ex_en     = !frozen;
      ex_mem_en    = !frozen;
      mem_wb_en    = !frozen;
      if_id_flush  = branch;
      id_ex_flush  = branch || stall;
      ex_mem_flush = branch;

      id_byp_a = id_valid && id_uses_rs &&
                 tag_match(wb_q.valid, wb_q.regwrite, wb_q.dst, id_rs_w);
      id_byp_b = id_valid && id_uses_rt &&
                 tag_match(wb_q.valid, wb_q.regwrite, wb_q.dst, id_rt_w);
   end

   // Shadow next-state: hold while frozen, bubble wherever a flush is asserted.
   always_comb begin
      ex_d  = ex_q;
      mem_d = mem_q;
      wb_d  = wb_q;
      if (!frozen) begin
         if (id_ex_flush) begin
            ex_d = '0;
         end else begin
            ex_d.valid    = id_valid;
            ex_d.rs       = id_rs_w;
            ex_d.rt       = id_rt_w;
            ex_d.dst      = id_dst_w;
            ex_d.regwrite = id_regwrite;
            ex_d.memread  = id_memread;
         end
         if (ex_mem_flush) begin
            mem_d = '0;
         end else begin
            mem_d.valid    = ex_q.valid;
            mem_d.dst      = ex_q.dst;
            mem_d.regwrite = ex_q.regwrite;
            mem_d.memread  = ex_q.memread;
         end
         wb_d.valid    = mem_q.valid;
         wb_d.dst      = mem_q.dst;
         // The taken branch itself moves into WB but never writes a register.
         wb_d.regwrite = mem_q.regwrite && !branch;
      end
   end

   always_ff @(posedge clk or negedge startin) begin
      if (!startin) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else begin
         ex_q  <= ex_d;
         mem_q <= mem_d;
         wb_q  <= wb_d;
      end
   end

   // Freeze starts when a load lands in MEM and lasts MEM_LAT-1 cycles.
   always_ff @(posedge clk or negedge startin) begin
      if (!startin) begin
         frz_q     <= StRun;
         lat_cnt_q <= '0;
      end else begin
         case (frz_q)
            StRun: begin
               if (FreezeEn && mem_d.valid && mem_d.memread) begin
                  frz_q     <= StFreeze;
                  lat_cnt_q <= '0;
               end
            end
            StFreeze: begin
               if (lat_cnt_q == LatLast) begin
                  frz_q     <= StRun;
                  lat_cnt_q <= '0;
               end else begin
                  lat_cnt_q <= lat_cnt_q + 4'd1;
               end
            end
            default: begin
               frz_q     <= StRun;
               lat_cnt_q <= '0;
            end
         endcase
      end
   end

   hazard_fwd_sel u_fwd_a (
      .operand_i (ex_q.rs),
      .mem_tag_i (mem_q),
      .wb_tag_i  (wb_q),
      .sel_o     (fwd_a)
   );

   hazard_fwd_sel u_fwd_b (
      .operand_i (ex_q.rt),
      .mem_tag_i (mem_q),
      .wb_tag_i  (wb_q),
      .sel_o     (fwd_b)
   );

`ifdef HAZARD_PERF_EN
   logic [PERF_W-1:0] stall_cnt_q;
   logic [PERF_W-1:0] flush_cnt_q;

   always_ff @(posedge clk or negedge startin) begin
      if (!startin) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if ((stall || frozen) && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
         end
         if (branch && (flush_cnt_q != '1)) begin
            flush_cnt_q <= flush_cnt_q + 1'b1;
         end
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench for pipe_hazard_unit: one instance with MEM_LAT=1, one with MEM_LAT=3.
module tb_pipe_hazard_unit;

   logic       clk = 1'b0;
   logic       startin;
   logic       id_valid;
   logic [4:0] id_rs, id_rt, id_dst;
   logic       id_uses_rs, id_uses_rt, id_regwrite, id_memread;
   logic       mem_branch_taken;

   logic       pc_en1, if_id_en1, id_ex_en1, ex_mem_en1, mem_wb_en1;
   logic       if_id_flush1, id_ex_flush1, ex_mem_flush1, id_byp_a1, id_byp_b1;
   logic [1:0] fwd_a1, fwd_b1;
   logic       pc_en3, if_id_en3, id_ex_en3, ex_mem_en3, mem_wb_en3;
   logic       if_id_flush3, id_ex_flush3, ex_mem_flush3, id_byp_a3, id_byp_b3;
   logic [1:0] fwd_a3, fwd_b3;
`ifdef HAZARD_PERF_EN
   logic [31:0] stall_cnt1, flush_cnt1, stall_cnt3, flush_cnt3;
`endif

   always #5 clk = ~clk;

   pipe_hazard_unit #(.REG_AW(5), .MEM_LAT(1), .PERF_W(32)) u_dut1 (
      .clk(clk), .startin(startin), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst),
      .id_regwrite(id_regwrite), .id_memread(id_memread), .mem_branch_taken(mem_branch_taken),
      .pc_en(pc_en1), .if_id_en(if_id_en1), .id_ex_en(id_ex_en1), .ex_mem_en(ex_mem_en1),
      .mem_wb_en(mem_wb_en1), .if_id_flush(if_id_flush1), .id_ex_flush(id_ex_flush1),
      .ex_mem_flush(ex_mem_flush1), .fwd_a(fwd_a1), .fwd_b(fwd_b1),
`ifdef HAZARD_PERF_EN
      .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1),
`endif
      .id_byp_a(id_byp_a1), .id_byp_b(id_byp_b1)
   );

   pipe_hazard_unit #(.REG_AW(5), .MEM_LAT(3), .PERF_W(32)) u_dut3 (
      .clk(clk), .startin(startin), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst),
      .id_regwrite(id_regwrite), .id_memread(id_memread), .mem_branch_taken(mem_branch_taken),
      .pc_en(pc_en3), .if_id_en(if_id_en3), .id_ex_en(id_ex_en3), .ex_mem_en(ex_mem_en3),
      .mem_wb_en(mem_wb_en3), .if_id_flush(if_id_flush3), .id_ex_flush(id_ex_flush3),
      .ex_mem_flush(ex_mem_flush3), .fwd_a(fwd_a3), .fwd_b(fwd_b3),
`ifdef HAZARD_PERF_EN
      .stall_cnt(stall_cnt3), .flush_cnt(flush_cnt3),
`endif
      .id_byp_a(id_byp_a3), .id_byp_b(id_byp_b3)
   );

   // {enables[4:0], flushes[2:0], fwd_a, fwd_b, byp_a, byp_b}
   logic [13:0] obs1, obs3;
   assign obs1 = {pc_en1, if_id_en1, id_ex_en1, ex_mem_en1, mem_wb_en1, if_id_flush1,
                  id_ex_flush1, ex_mem_flush1, fwd_a1, fwd_b1, id_byp_a1, id_byp_b1};
   assign obs3 = {pc_en3, if_id_en3, id_ex_en3, ex_mem_en3, mem_wb_en3, if_id_flush3,
                  id_ex_flush3, ex_mem_flush3, fwd_a3, fwd_b3, id_byp_a3, id_byp_b3};

   typedef struct {
      string       tag;
      bit          d3;
      logic [13:0] exp;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_bad = 0;

   function automatic logic [13:0] mk(input logic [4:0] en, input logic [2:0] fl,
                                      input logic [1:0] fa, input logic [1:0] fb,
                                      input logic ba, input logic bb);
      return {en, fl, fa, fb, ba, bb};
   endfunction

   task automatic id_set(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic [4:0] dst,
                         input logic rw, input logic mr);
      id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
      id_dst = dst; id_regwrite = rw; id_memread = mr;
   endtask

   task automatic id_idle();
      id_set(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
   endtask

   task automatic expect_out(input string tag, input bit d3, input logic [13:0] e);
      exp_t x;
      x.tag = tag; x.d3 = d3; x.exp = e;
      sb.push_back(x);
   endtask

   task automatic check_out();
      exp_t        x;
      logic [13:0] o;
      n_vec++;
      if (sb.size() == 0) begin
         n_bad++;
         $error("FAIL scoreboard: observed empty queue required one entry");
      end else begin
         x = sb.pop_front();
         o = x.d3 ? obs3 : obs1;
         assert (o === x.exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b required %b", x.tag, o, x.exp);
         end
      end
   endtask

   task automatic cyc(input string tag, input bit d3, input logic [13:0] e);
      expect_out(tag, d3, e);
      @(negedge clk);
      check_out();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      id_idle();
      mem_branch_taken = 1'b0;
      startin = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      startin = 1'b1;
      @(posedge clk);
      #1;
   endtask

   localparam logic [13:0] NOM    = 14'b11111_000_00_00_0_0;
   localparam logic [13:0] STALL  = 14'b00111_010_00_00_0_0;
   localparam logic [13:0] FREEZE = 14'b00000_000_00_00_0_0;
   localparam logic [13:0] BRANCH = 14'b11111_111_00_00_0_0;

   initial begin
      id_idle();
      mem_branch_taken = 1'b0;
      startin = 1'b0;
      #1;
      expect_out("reset_lat1", 1'b0, NOM);
      expect_out("reset_lat3", 1'b1, NOM);
      check_out();
      check_out();

      // lw $2,0($1); add $3,$2,$4
      do_reset();
      id_set(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1);
      cyc("t1_lw_id", 1'b0, NOM);
      id_set(1'b1, 5'd2, 5'd4, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
      cyc("t1_loaduse_stall", 1'b0, STALL);
      cyc("t1_stall_released", 1'b0, NOM);
      id_idle();
      cyc("t1_add_ex_fwd_wb", 1'b0, mk(5'b11111, 3'b000, 2'b01, 2'b00, 1'b0, 1'b0));

      // add $2,$1,$1; sub $5,$2,$2; or $6,$2,$7
      do_reset();
      id_set(1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0);
      cyc("t2_add_id", 1'b0, NOM);
      id_set(1'b1, 5'd2, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
      cyc("t2_sub_id_no_stall", 1'b0, NOM);
      id_idle();
      cyc("t2_sub_ex_fwd_mem", 1'b0, mk(5'b11111, 3'b000, 2'b10, 2'b10, 1'b0, 1'b0));
      id_set(1'b1, 5'd2, 5'd7, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
      cyc("t2_id_bypass_a", 1'b0, mk(5'b11111, 3'b000, 2'b00, 2'b00, 1'b1, 1'b0));

      // addi $0,$1,5; add $3,$0,$0
      do_reset();
      id_set(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
      cyc("t3_addi_id", 1'b0, NOM);
      id_set(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
      cyc("t3_add_id", 1'b0, NOM);
      id_idle();
      cyc("t3_r0_no_fwd_mem", 1'b0, NOM);
      id_set(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
      cyc("t3_r0_no_fwd_wb_byp", 1'b0, NOM);

      // add $4,$1,$1; lw $2,0($1); add $3,$2,$4 with a taken branch in MEM
      do_reset();
      id_set(1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
      cyc("t4_add4_id", 1'b0, NOM);
      id_set(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1);
      cyc("t4_lw_id", 1'b0, NOM);
      id_set(1'b1, 5'd2, 5'd4, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
      mem_branch_taken = 1'b1;
      cyc("t4_branch_beats_stall", 1'b0, BRANCH);
      mem_branch_taken = 1'b0;
      id_set(1'b1, 5'd4, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
      cyc("t4_after_flush_id", 1'b0, NOM);
      id_idle();
      cyc("t4_after_flush_ex", 1'b0, NOM);

      // MEM_LAT=3: lw $2; add $7,$1,$1; add $3,$2,$4
      do_reset();
      id_set(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1);
      cyc("t5_lw_id", 1'b1, NOM);
      id_set(1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
      cyc("t5_add7_id", 1'b1, NOM);
      id_set(1'b1, 5'd2, 5'd4, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
      mem_branch_taken = 1'b1;
      cyc("t5_freeze_c0_branch_ignored", 1'b1, FREEZE);
      mem_branch_taken = 1'b0;
      cyc("t5_freeze_c1", 1'b1, FREEZE);
      cyc("t5_release", 1'b1, NOM);
      id_idle();
      cyc("t5_dep_fwd_wb", 1'b1, mk(5'b11111, 3'b000, 2'b01, 2'b00, 1'b0, 1'b0));

      // MEM_LAT=3: reset pulsed during the freeze
      do_reset();
      id_set(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1);
      cyc("t6_lw_id", 1'b1, NOM);
      id_idle();
      cyc("t6_lw_ex", 1'b1, NOM);
      expect_out("t6_frozen", 1'b1, FREEZE);
      @(negedge clk);
      check_out();
      #1 startin = 1'b0;
      expect_out("t6_async_reset", 1'b1, NOM);
      #1 check_out();
      #1 startin = 1'b1;
      @(posedge clk);
      #1;
      id_set(1'b1, 5'd2, 5'd2, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
      cyc("t6_shadow_empty_id", 1'b1, NOM);
      id_idle();
      cyc("t6_shadow_empty_ex", 1'b1, NOM);

      if (sb.size() != 0) begin
         n_bad++;
         $error("FAIL scoreboard_drain: observed %0d entries required 0", sb.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_unit.md
Name: pipe_hazard_unit

Overview:
- Parametrised hazard and forwarding controller for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB); successor to the hazard-free pipeline top.
- Keeps a shadow tag pipeline (EX, MEM, WB slots) of in-flight register writes.
- From it, produces: per-stage register enables, flushes, EX-stage forwarding selects, ID-stage write-through bypass.
- Adds handling the current core lacks: load-use stall, taken-branch flush, and a multi-cycle data-memory freeze (MEM_LAT).

Parameters:
REG_AW, 5, register-number width.
MEM_LAT, 1, data-memory load latency in cycles (1..15); 1 = no freeze.
PERF_W, 32, width of performance counters (optional feature only).

Ports:
clk  in  1  pipeline clock, rising edge.
startin  in  1  asynchronous active-low reset.
id_valid  in  1  IF/ID holds a real instruction.
id_rs  in  REG_AW  ID instr[25:21].
id_rt  in  REG_AW  ID instr[20:16].
id_uses_rs  in  1  ID instruction reads rs.
id_uses_rt  in  1  ID instruction reads rt.
id_dst  in  REG_AW  ID destination after RegDst selection.
id_regwrite  in  1  ID control RegWrite.
id_memread  in  1  ID control MemRead.
mem_branch_taken  in  1  branch AND zero in MEM.
pc_en  out  1  PC load enable.
if_id_en  out  1  IF/ID enable.
id_ex_en  out  1  ID/EX enable.
ex_mem_en  out  1  EX/MEM enable.
mem_wb_en  out  1  MEM/WB enable.
if_id_flush  out  1  load NOP into IF/ID.
id_ex_flush  out  1  load bubble into ID/EX.
ex_mem_flush  out  1  load bubble into EX/MEM.
fwd_a  out  2  EX operand A select: 00 regfile, 01 MEM/WB, 10 EX/MEM.
fwd_b  out  2  EX operand B select, same encoding.
id_byp_a  out  1  ID rs read takes WB write data.
id_byp_b  out  1  ID rt read takes WB write data.

Behaviour:
- Reset (startin=0, async): all shadow slots invalid; latency counter 0; all enables 1; all flushes 0; fwd_* 00; id_byp_* 0. Applies immediately, including mid-freeze.
- Shadow slots:
  - EX slot holds {valid, rs, rt, dst, regwrite, memread}.
  - MEM slot holds {valid, dst, regwrite, memread}.
  - WB slot holds {valid, dst, regwrite}.
  - Slots advance on every edge where not frozen. Bubbles are inserted exactly where the matching flush is asserted.
- Match rule: slot valid AND regwrite AND dst != 0 AND dst equals the operand. Register $0 never matches.
- Forwarding (combinational):
  - fwd_a = 10 if the MEM slot matches EX.rs and MEM is not a load.
  - Otherwise fwd_a = 01 if the WB slot matches.
  - Otherwise fwd_a = 00.
  - fwd_b is the same rule applied to EX.rt.
- ID bypass: id_byp_a = id_valid AND id_uses_rs AND WB matches id_rs. id_byp_b is the same for rt.
- Load-use stall:
  - Condition: id_valid AND the EX slot is a valid load AND EX matches a used id_rs/id_rt.
  - Action: pc_en=0, if_id_en=0, id_ex_flush=1 for exactly one cycle.
  - The EX slot becomes a bubble; MEM and WB advance.
- Memory freeze (MEM_LAT>1):
  - When the MEM slot holds a valid load, the counter runs 0..MEM_LAT-2.
  - While it runs, all five enables are 0 and the shadow is held.
  - The edge after the counter reaches MEM_LAT-2, the counter clears, enables return to 1 and the slots advance.
  - Freeze takes priority over load-use stall; the stall is re-evaluated after release.
- Branch flush:
  - mem_branch_taken=1 (sampled only when not frozen) asserts if_id_flush, id_ex_flush and ex_mem_flush for one cycle, with pc_en=1.
  - Shadow: EX and MEM become bubbles; WB takes the branch tag (regwrite=0).
  - Branch flush overrides a coincident load-use stall; no stall is asserted that cycle.
- Flushes and stalls never assert while frozen.

Optional Feature:
- Macro HAZARD_PERF_EN.
- With it defined, the block adds two outputs, stall_cnt and flush_cnt (PERF_W each, saturating, reset 0):
  - stall_cnt increments on each load-use-stall or freeze cycle.
  - flush_cnt increments on each branch-flush cycle.
- Without it, these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package pipe_pkg holds:
  - FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - Shadow-slot typedef structs (ex_tag_t, mem_tag_t, wb_tag_t).
  - The shared match function.
- One sub-module, hazard_fwd_sel: combinational single-operand forwarding selector, instantiated for A and B.

Test Plan:
1. lw $2,0($1) then add $3,$2,$4 -> exactly 1 cycle with pc_en=0, if_id_en=0, id_ex_flush=1; the next cycle with add in EX gives fwd_a=01.
2. add $2,$1,$1 then sub $5,$2,$2 -> no stall; with sub in EX, fwd_a=10 and fwd_b=10.
3. addi $0,$1,5 then add $3,$0,$0 -> no stall; fwd_a=fwd_b=00 throughout.
4. mem_branch_taken=1 while a load-use hazard sits in ID -> all three flushes=1 for 1 cycle, pc_en=1, no stall; the following cycle shows no forwards.
5. MEM_LAT=3: lw in MEM -> all enables 0 for 2 cycles, then 1; a dependent instruction two behind gets fwd_a=01.
6. startin pulsed low during cycle 1 of a MEM_LAT=3 freeze -> enables 1, flushes 0, fwd 00 immediately; the shadow is empty after release.
